// File: rtl/decoder_3x8_hold_pkg.sv
// Shared widths, FSM state type and the one-hot helper for the 3-to-8 hold decoder.
package decoder_pkg;

  localparam int DEC_W = 3;
  localparam int DEC_N = 8;

  typedef enum logic {
    DEC_IDLE  = 1'b0,
    DEC_DRIVE = 1'b1
  } dec_state_t;

  function automatic logic [DEC_N-1:0] dec_onehot(input logic [DEC_W-1:0] c);
    dec_onehot    = '0;
    dec_onehot[c] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_3x8_hold_hold_counter.sv
// Loadable down-counter that times how long the decoder holds its output line.
module hold_counter #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  output logic [HOLD_W-1:0] cnt,
  output logic              last
);

  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] w_load_val;

  // A requested hold of zero still has to show the line for one cycle.
  assign w_load_val = (load_val == '0) ? HOLD_W'(1) : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HOLD_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == HOLD_W'(1));

endmodule

// File: rtl/decoder_3x8_hold.sv
// Registered 3-to-8 one-hot decoder that holds each line for a programmable time.
// Optional saturating accept counter enabled by DECODER_ACC_CNT_EN.
module decoder_3x8_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEC_W-1:0]  code,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [DEC_N-1:0]  y,
  output logic              y_valid,
  output logic              busy,
`ifdef DECODER_ACC_CNT_EN
  output logic [7:0]        acc_cnt,
`endif
  output dec_state_t        dbg_state
);

  // Handshake: a transfer happens on a rising edge with in_valid && in_ready;
  // code/hold_len are sampled only then, and in_ready depends on registered
  // state alone (never on in_valid).

  dec_state_t        r_state;
  logic [DEC_N-1:0]  r_y;
  logic              r_y_valid;
  logic              r_busy;
  logic              w_xfer;
  logic              w_last;
  logic [HOLD_W-1:0] w_cnt;

  assign in_ready = (r_state == DEC_IDLE) || w_last;
  assign w_xfer   = in_valid && in_ready;

  hold_counter #(
    .HOLD_W (HOLD_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_xfer),
    .load_val (hold_len),
    .cnt      (w_cnt),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DEC_IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        DEC_IDLE: begin
          if (w_xfer) begin
            r_y       <= dec_onehot(code);
            r_y_valid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= DEC_DRIVE;
          end
        end
        DEC_DRIVE: begin
          if (w_last) begin
            // Reloading on the last cycle chains codes with no zero gap.
            if (w_xfer) begin
              r_y       <= dec_onehot(code);
              r_y_valid <= 1'b1;
            end else begin
              r_y       <= '0;
              r_y_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= DEC_IDLE;
            end
          end
        end
        default: begin
          r_state   <= DEC_IDLE;
          r_y       <= '0;
          r_y_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign busy      = r_busy;
  assign dbg_state = r_state;

`ifdef DECODER_ACC_CNT_EN
  logic [7:0] r_acc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= 8'h00;
    end else if (w_xfer && (r_acc_cnt != 8'hFF)) begin
      r_acc_cnt <= r_acc_cnt + 8'h01;
    end
  end

  assign acc_cnt = r_acc_cnt;
`else
  // The counter value is unused here; keep the hold count observable to lint.
  logic w_cnt_unused;
  assign w_cnt_unused = ^w_cnt;
`endif

endmodule
